// File: rtl/ltmr_counter.sv
// Local-TMR protected up-counter: three replica registers, bitwise majority vote,
// voted-value feedback for scrubbing, mismatch reporting and fault injection.
module ltmr_counter #(
    parameter int WIDTH         = 8,
    parameter int ERR_CNT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     port_en,
    input  logic                     port_load,
    input  logic [WIDTH-1:0]         port_load_val,
    input  logic [1:0]               port_fault_sel,
    input  logic [WIDTH-1:0]         port_fault_mask,
    input  logic                     port_err_clr,
    output logic [WIDTH-1:0]         port_out,
    output logic                     port_err,
    output logic [2:0]               port_err_replica,
    output logic [ERR_CNT_WIDTH-1:0] port_err_cnt
);

    logic [2:0][WIDTH-1:0]    replica_q;
    logic [WIDTH-1:0]         vote;
    logic [WIDTH-1:0]         count_next;
    logic [2:0]               mism;
    logic                     err_reg;
    logic [2:0]               err_replica_reg;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_reg;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_next;

    assign vote = (replica_q[0] & replica_q[1])
                | (replica_q[0] & replica_q[2])
                | (replica_q[1] & replica_q[2]);

    always_comb begin
        count_next = vote;
        if (port_load) begin
            count_next = port_load_val;
        end else if (port_en) begin
            count_next = vote + WIDTH'(1);
        end
    end

    // Every replica reloads from the vote, so a corrupted replica is overwritten
    // at the next edge instead of propagating its own bad state.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_replica
            logic [WIDTH-1:0] replica_reg;
            logic [WIDTH-1:0] replica_next;

            assign replica_next = count_next
                ^ ((port_fault_sel == 2'(gi + 1)) ? port_fault_mask : '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    replica_reg <= '0;
                end else begin
                    replica_reg <= replica_next;
                end
            end

            assign replica_q[gi] = replica_reg;
            assign mism[gi]      = |(replica_reg ^ vote);
        end
    endgenerate

    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (port_err_clr) begin
            err_cnt_next = '0;
        end else if ((|mism) && (err_cnt_reg != '1)) begin
            err_cnt_next = err_cnt_reg + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg         <= 1'b0;
            err_replica_reg <= '0;
            err_cnt_reg     <= '0;
        end else begin
            err_reg         <= |mism;
            err_replica_reg <= mism;
            err_cnt_reg     <= err_cnt_next;
        end
    end

    assign port_out         = vote;
    assign port_err         = err_reg;
    assign port_err_replica = err_replica_reg;
    assign port_err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_ltmr_counter.sv
// Scoreboard bench for ltmr_counter: the stimulus side predicts each post-edge
// output from the counting/scrubbing rules, a monitor compares after every edge.
module tb_ltmr_counter;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  lval = '0;
    logic [W-1:0]  mask = '0;
    logic [1:0]    sel = '0;
    logic [W-1:0]  port_out;
    logic          port_err;
    logic [2:0]    port_err_replica;
    logic [CW-1:0] port_err_cnt;

    ltmr_counter #(.WIDTH(W), .ERR_CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .port_en          (en),
        .port_load        (load),
        .port_load_val    (lval),
        .port_fault_sel   (sel),
        .port_fault_mask  (mask),
        .port_err_clr     (clr),
        .port_out         (port_out),
        .port_err         (port_err),
        .port_err_replica (port_err_replica),
        .port_err_cnt     (port_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int out;
        int err;
        int rep;
        int cnt;
    } exp_t;

    exp_t q[$];
    int compared   = 0;
    int mismatched = 0;
    int txn        = 0;

    // Reference state: the counter's true value, the one-hot replica left
    // corrupted by the last edge (0 = none), and the error count.
    int m_val  = 0;
    int m_pend = 0;
    int m_cnt  = 0;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int e, input int l, input int lv, input int s,
                       input int mk, input int c);
        exp_t x;
        @(negedge clk);
        en   = (e != 0);
        load = (l != 0);
        lval = W'(lv);
        sel  = 2'(s);
        mask = W'(mk);
        clr  = (c != 0);
        x.rep = m_pend;
        x.err = (m_pend != 0) ? 1 : 0;
        if (c != 0) m_cnt = 0;
        else if (m_pend != 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        x.cnt = m_cnt;
        if (l != 0) m_val = lv % 256;
        else if (e != 0) m_val = (m_val + 1) % 256;
        x.out = m_val;
        m_pend = (s != 0 && (mk % 256) != 0) ? (1 << (s - 1)) : 0;
        q.push_back(x);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"}, int'(port_out), 0);
        chk({tag, "_err"}, int'(port_err), 0);
        chk({tag, "_rep"}, int'(port_err_replica), 0);
        chk({tag, "_cnt"}, int'(port_err_cnt), 0);
    endtask

    // Monitor: the DUT presents a new result after every active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t x;
                x = q.pop_front();
                txn++;
                $display("txn %0d: out=%02h err=%0b rep=%03b cnt=%0d | exp out=%02h err=%0d rep=%0d cnt=%0d",
                         txn, port_out, port_err, port_err_replica, port_err_cnt,
                         x.out, x.err, x.rep, x.cnt);
                chk("out", int'(port_out), x.out);
                chk("err", int'(port_err), x.err);
                chk("err_replica", int'(port_err_replica), x.rep);
                chk("err_cnt", int'(port_err_cnt), x.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain counting from reset.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);

        // Load all-ones, wrap, then load beats enable.
        cyc(0, 1, 8'hFF, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 8'h3C, 0, 0, 0);

        // Single fault on replica 1 while counting.
        cyc(1, 0, 0, 2, 8'h81, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);

        // Faults hopping across replicas on consecutive edges.
        cyc(1, 0, 0, 1, 8'h10, 0);
        cyc(1, 0, 0, 3, 8'h03, 0);
        cyc(0, 0, 0, 2, 8'hF0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Continuous fault saturates the counter; clear wins over a live mismatch.
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 2, 8'h01, 0);
        cyc(1, 0, 0, 2, 8'h01, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 8'h42, 3, 8'h80, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Asynchronous reset between edges with a fault active.
        @(negedge clk);
        en   = 1'b1;
        sel  = 2'b11;
        mask = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0; sel = '0; mask = '0;
        m_val = 0; m_pend = 0; m_cnt = 0;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            int l, s;
            l = ($urandom_range(0, 15) == 0) ? 1 : 0;
            s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            cyc(int'($urandom_range(0, 3) != 0), l, int'($urandom_range(0, 255)),
                s, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 19) == 0));
        end
        cyc(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ltmr_counter.md
# ltmr_counter

Parametrised local-TMR up-counter: three replica state registers, bitwise majority voter, and voted-value feedback so a single upset replica is scrubbed on the next clock edge. Adds per-replica mismatch reporting, a saturating error counter, and a per-replica fault-injection port so fault-analysis benches can exercise the countermeasure deterministically. Drop-in protected state element for counters and FSM state in LTMR-hardened datapaths.

## Interface

- WIDTH, 8, counter/replica width in bits (≥1)
- ERR_CNT_WIDTH, 4, width of saturating mismatch counter (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- port_en  in  1  increment voted value this cycle
- port_load  in  1  load port_load_val into all replicas; priority over port_en
- port_load_val  in  WIDTH  load value
- port_fault_sel  in  2  00 none, 01 replica 0, 10 replica 1, 11 replica 2
- port_fault_mask  in  WIDTH  XORed into selected replica's next-state
- port_err_clr  in  1  synchronous clear of port_err_cnt
- port_out  out  WIDTH  voted value, combinational from replica registers
- port_err  out  1  registered: some replica disagreed with vote in previous cycle
- port_err_replica  out  3  registered one-hot-or-zero: bit i = replica i disagreed in previous cycle
- port_err_cnt  out  ERR_CNT_WIDTH  count of cycles with any mismatch, saturating

## Operation

- Replicas r0, r1, r2 (WIDTH each). Vote v = bitwise maj(r0,r1,r2); port_out = v.
- Next value n: port_load ? port_load_val : port_en ? v+1 (mod 2^WIDTH) : v.
- Replica i next-state: n XOR (port_fault_sel == i+1 ? port_fault_mask : 0). Unselected replicas get n.
- All replicas derive from v, never from own state: any single-replica corruption removed at next edge (scrubbing).
- mism_i = OR-reduce(r_i XOR v). Any mism_i → that cycle counts as error.
- port_err_replica <= {mism2,mism1,mism0}; port_err <= mism0|mism1|mism2.
- port_err_cnt: port_err_clr → 0 (clear wins over simultaneous mismatch); else any mism and cnt ≠ all-ones → cnt+1; else hold.
- Single-bit-per-position majority always exists; two replicas corrupted identically in the same bit are outvoted-wrong by design (out of fault model, not flagged beyond mism of the correct replica).

## Timing

- Reset (rst_n low, async): r0=r1=r2=0, port_out=0, port_err=0, port_err_replica=0, port_err_cnt=0. Release synchronous to clk by integrator.
- port_out changes one edge after load/en (1-cycle latency); wrap all-ones+en → 0.
- Fault injected with sel/mask sampled at edge k: replica wrong after k, port_out unchanged, mism visible k..k+1, replica restored at edge k+1, port_err/port_err_replica high for exactly cycle after k+1, port_err_cnt +1 after k+1.
- Fault sel held for N consecutive edges on same replica: port_err high N cycles, cnt +N (saturating), port_out never disturbed.
- Fault on different replicas on consecutive edges: previous one already scrubbed; output undisturbed.
- Load/en with simultaneous fault: fault applies on top of new value for selected replica only.
- Reset mid-operation: all state cleared immediately, regardless of pending fault/err.

## Test plan

- Reset then port_en=1 for 5 cycles (WIDTH=8) -> port_out 0,1,2,3,4,5; port_err 0 throughout; port_err_cnt 0.
- port_load=1, port_load_val=8'hFF, then port_en=1 -> port_out 8'hFF then 8'h00 (wrap); port_load with port_en both high loads, no increment.
- Counting, one cycle fault_sel=2'b10, mask=8'h81 -> port_out sequence unchanged; port_err=1 and port_err_replica=3'b010 for exactly one cycle, one cycle after injection; port_err_cnt=1.
- Fault replica 0, then replica 2 on next edge, then replica 1 -> port_out undisturbed; port_err_replica 001,100,010 in consecutive cycles; cnt=3.
- ERR_CNT_WIDTH=4, continuous fault for 20 cycles -> cnt saturates at 4'hF; assert port_err_clr with mismatch active -> cnt=0 next cycle.
- Assert rst_n low mid-count with fault active, between edges -> all outputs 0 immediately without clock edge; after release count restarts from 0.
